addsub_sequencer: RTL and testbench
===================================

# addsub_sequencer

Multi-cycle controller that computes WIDTH-bit add or subtract by sequencing one shared 4-bit ripple-carry adder-subtractor slice, one nibble per cycle, LSB nibble first. A registered carry links the nibbles. It accepts operands through a valid/ready handshake and holds the result until the consumer takes it. It sits between the operand source and any consumer that can tolerate WIDTH/4-cycle latency in exchange for a single 4-bit slice.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  high only in IDLE.
- a  input  WIDTH  operand A; captured on accept.
- b  input  WIDTH  operand B; captured on accept.
- op  input  1  0 = A+B, 1 = A-B (two's complement); captured on accept.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  result.
- c  output  1  carry out of the MSB; for subtract, 1 = no borrow (A >= B unsigned).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN or DONE.
- abort  input  1  present only with ADDSUB_SEQ_ABORT_EN.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- Reset values: s=0, c=0, ovf=0, out_valid=0, busy=0, in_ready=1, nibble index=0, carry register=0.
- IDLE: if in_valid is high at a clock edge, the block:
  - latches a, b, op;
  - loads the carry register with op (the +1 of the subtract);
  - sets the index to 0;
  - enters RUN.
- RUN, each cycle, nibble k = index:
  - slice computes A[4k+3:4k] + (B[4k+3:4k] XOR {4{op}}) + carry;
  - the 4-bit sum is written into s[4k+3:4k];
  - the carry register takes the slice carry out;
  - index increments.
- At the last nibble (index = WIDTH/4-1), the block also:
  - writes c = slice carry out;
  - writes ovf = slice carry out XOR carry into slice bit 3;
  - enters DONE.
- DONE: out_valid=1; s, c, ovf are stable. If out_ready is high at an edge, go to IDLE. There is no accept in the same cycle.
- in_valid is ignored outside IDLE, and operand inputs may change freely then.
- s updates nibble-by-nibble during RUN. Its contents are defined only while out_valid=1.
- Starting a new operation does not clear s, c, ovf; they are overwritten as the operation runs.
- rst asserted in any state forces the reset values immediately, regardless of clock. The in-flight operation is discarded.

## Timing
- N = WIDTH/4.
- The accept edge is E0; nibble k is written at edge E(k+1); out_valid rises after edge EN. Latency from accept to out_valid is N cycles.
- Minimum issue interval is N+2 cycles: N in RUN, 1 in DONE with out_ready=1, 1 in IDLE.
- out_valid stays high for any number of cycles while out_ready=0. Outputs hold bit-exact.
- in_ready and out_valid are decoded from state registers only, with no combinational path from in_valid or out_ready.

## Configuration
- ADDSUB_SEQ_ABORT_EN defined:
  - the abort port exists;
  - abort high at an edge while in RUN or DONE returns the block to IDLE next cycle;
  - out_valid is never asserted for the aborted operation;
  - s, c, ovf keep their partial values;
  - abort is ignored in IDLE.
- Not defined: no abort port; every accepted operation completes to DONE.

## Test plan
All scenarios use WIDTH=16.
- Add: a=0x1234, b=0x0FFF, op=0 -> s=0x2233, c=0, ovf=0. out_valid rises exactly 4 cycles after accept.
- Signed overflow: 0x7FFF+0x0001 op=0 -> s=0x8000, c=0, ovf=1. 0xFFFF+0xFFFF op=0 -> s=0xFFFE, c=1, ovf=0.
- Subtract: 0x0003-0x0005 op=1 -> s=0xFFFE, c=0, ovf=0. 0x8000-0x0001 op=1 -> s=0x7FFF, c=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. The bench requires:
  - s/c/ovf stable and in_ready=0 throughout;
  - in_valid pulsed with new operands during RUN and DONE is not accepted;
  - after out_ready=1, one cycle of IDLE, then the next accept.
- Reset mid-RUN: assert rst asynchronously after nibble 1. Outputs go to reset values immediately. After release, in_ready=1 and a fresh 0x0001+0x0001 gives s=0x0002.
- With ADDSUB_SEQ_ABORT_EN: abort in the 2nd RUN cycle -> IDLE next cycle, no out_valid pulse, in_ready=1.

Source files
------------

// File: rtl/addsub_sequencer_if.sv
// -----------------------------------------------------------------------------
// addsub_sequencer_if
//
// Handshake and data bundle for addsub_sequencer.
//   master : operand source and result consumer side.
//   slave  : the sequencer itself.
//
// Signals:
//   in_valid  (master->slave) operand request
//   in_ready  (slave->master) sequencer idle, will accept on next edge
//   a, b      (master->slave) WIDTH-bit operands, captured on accept
//   op        (master->slave) 0 = A+B, 1 = A-B
//   out_ready (master->slave) consumer takes the result
//   out_valid (slave->master) result valid
//   s         (slave->master) WIDTH-bit result
//   c         (slave->master) carry out of the MSB (subtract: 1 = no borrow)
//   ovf       (slave->master) signed overflow
//   busy      (slave->master) operation in flight or result pending
//   abort     (master->slave) only when ADDSUB_SEQ_ABORT_EN is defined
// -----------------------------------------------------------------------------
interface addsub_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c;
  logic             ovf;
  logic             busy;

`ifdef ADDSUB_SEQ_ABORT_EN
  logic             abort;

  modport master (
    output in_valid, a, b, op, out_ready, abort,
    input  in_ready, out_valid, s, c, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready, abort,
    output in_ready, out_valid, s, c, ovf, busy
  );
`else
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, s, c, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, s, c, ovf, busy
  );
`endif
endinterface

// File: rtl/addsub_sequencer.sv
// -----------------------------------------------------------------------------
// addsub_sequencer
//
// Computes a WIDTH-bit add or subtract using a single 4-bit ripple-carry
// adder-subtractor slice, one nibble per cycle, LSB nibble first. A registered
// carry links successive nibbles. Operands arrive over a valid/ready handshake
// and the result is held until the consumer accepts it.
//
// Latency from accept to out_valid is WIDTH/4 cycles; minimum issue interval
// is WIDTH/4 + 2 cycles.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : addsub_sequencer_if.slave (handshake, operands, result, status)
//
// Build option:
//   ADDSUB_SEQ_ABORT_EN : adds bus.abort; abort in RUN or DONE returns to IDLE
//                         without raising out_valid, leaving s/c/ovf partial.
// -----------------------------------------------------------------------------
module addsub_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  addsub_sequencer_if.slave   bus
);

  localparam int               N     = WIDTH / 4;
  localparam int               IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("addsub_sequencer: WIDTH must be a multiple of 4 and at least 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // 4-bit ripple slice. Result layout: [5] carry into bit 3, [4] carry out,
  // [3:0] sum. The carry into bit 3 is needed for the signed-overflow flag.
  function automatic logic [5:0] slice4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       cin);
    logic [4:0] cy;
    logic [3:0] sm;
    cy[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sm[i]    = x[i] ^ y[i] ^ cy[i];
      cy[i+1]  = (x[i] & y[i]) | (x[i] & cy[i]) | (y[i] & cy[i]);
    end
    return {cy[3], cy[4], sm};
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             ovf_q, ovf_d;

  // Captured operands; only meaningful after an accept, so left unreset.
  logic [WIDTH-1:0] a_q, b_q;
  logic             op_q;
  logic             load;

  logic [3:0]       a_nib, b_nib;
  logic [5:0]       slice_res;
  logic             slice_c3, slice_cout;
  logic [3:0]       slice_sum;
  logic             abort_hit;

`ifdef ADDSUB_SEQ_ABORT_EN
  assign abort_hit = bus.abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Nibble select for the current index.
  always_comb begin
    a_nib = 4'h0;
    b_nib = 4'h0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IDX_W'(k)) begin
        a_nib = a_q[4*k +: 4];
        b_nib = b_q[4*k +: 4];
      end
    end
  end

  // Subtract is A + ~B + 1: the +1 enters as the initial carry loaded on accept.
  assign slice_res = slice4(a_nib, b_nib ^ {4{op_q}}, carry_q);
  assign {slice_c3, slice_cout, slice_sum} = slice_res;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    s_d     = s_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          carry_d = bus.op;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (abort_hit) begin
          // Partial result is left as-is; no nibble is written this cycle.
          state_d = IDLE;
        end else begin
          for (int k = 0; k < N; k++) begin
            if (idx_q == IDX_W'(k)) begin
              s_d[4*k +: 4] = slice_sum;
            end
          end
          carry_d = slice_cout;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == LAST) begin
            c_d     = slice_cout;
            ovf_d   = slice_cout ^ slice_c3;
            idx_d   = '0;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (abort_hit || bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      a_q  <= bus.a;
      b_q  <= bus.b;
      op_q <= bus.op;
    end
  end

  // Handshake outputs decode state only, so no comb path from in_valid/out_ready.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.s         = s_q;
  assign bus.c         = c_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_addsub_sequencer.sv
module tb_addsub_sequencer;

  localparam int W = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  addsub_sequencer_if #(.WIDTH(W)) bus ();

  addsub_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-word arithmetic, {ovf, c, s}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic sub);
    logic [15:0] yy;
    logic [16:0] full;
    logic        v;
    yy   = sub ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {16'd0, sub};
    v    = (x[15] == yy[15]) && (full[15] != x[15]);
    return {v, full[16], full[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE and collect the result; no checking here.
  task automatic do_op(input logic [15:0] oa, input logic [15:0] ob, input logic oop,
                       input int hold, output logic [15:0] rs, output logic rc,
                       output logic rovf, output int lat);
    bus.a         = oa;
    bus.b         = ob;
    bus.op        = oop;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    bus.a        = 16'($urandom);
    bus.b        = 16'($urandom);
    bus.op       = 1'($urandom);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    rs   = bus.s;
    rc   = bus.c;
    rovf = bus.ovf;
    repeat (hold) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if ({bus.s, bus.c, bus.ovf} !== 18'd0) begin errors++; $display("FAIL reset_result: got s=%h c=%b ovf=%b want 0/0/0", bus.s, bus.c, bus.ovf); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] ta [5] = '{16'h1234, 16'h7FFF, 16'hFFFF, 16'h0003, 16'h8000};
    logic [15:0] tb [5] = '{16'h0FFF, 16'h0001, 16'hFFFF, 16'h0005, 16'h0001};
    logic        to [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] es [5] = '{16'h2233, 16'h8000, 16'hFFFE, 16'hFFFE, 16'h7FFF};
    logic        ec [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        ev [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] rs;
    logic        rc, rv;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], to[i], 0, rs, rc, rv, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL dir_latency[%0d]: got %0d want 4", i, lat); end
      checks++; if (rs !== es[i]) begin errors++; $display("FAIL dir_s[%0d]: got %h want %h", i, rs, es[i]); end
      checks++; if (rc !== ec[i]) begin errors++; $display("FAIL dir_c[%0d]: got %b want %b", i, rc, ec[i]); end
      checks++; if (rv !== ev[i]) begin errors++; $display("FAIL dir_ovf[%0d]: got %b want %b", i, rv, ev[i]); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL dir_idle[%0d]: in_ready got %b want 1", i, bus.in_ready); end
    end
  endtask

  task automatic test_random();
    logic [15:0] x, y, rs;
    logic        o, rc, rv;
    logic [17:0] exp;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      x   = 16'($urandom);
      y   = 16'($urandom);
      o   = 1'($urandom);
      exp = model(x, y, o);
      do_op(x, y, o, $urandom_range(0, 2), rs, rc, rv, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d want 4", i, lat); end
      checks++; if ({rv, rc, rs} !== exp) begin errors++; $display("FAIL rnd_result[%0d] %h %s %h: got s=%h c=%b ovf=%b want s=%h c=%b ovf=%b", i, x, o ? "-" : "+", y, rs, rc, rv, exp[15:0], exp[16], exp[17]); end
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] exp, held;
    int          cnt;
    exp           = model(16'h4321, 16'h1111, 1'b1);
    bus.a         = 16'h4321;
    bus.b         = 16'h1111;
    bus.op        = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    cnt = 0;
    while (bus.out_valid !== 1'b1 && cnt < 20) begin
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_run_in_ready[%0d]: got %b want 0", cnt, bus.in_ready); end
      bus.in_valid = 1'b1;
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      bus.op       = 1'($urandom);
      tick();
      cnt++;
    end
    checks++; if (cnt !== 4) begin errors++; $display("FAIL bp_latency: got %0d want 4", cnt); end
    held = {bus.ovf, bus.c, bus.s};
    checks++; if (held !== exp) begin errors++; $display("FAIL bp_result: got %h want %h", held, exp); end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      tick();
      checks++; if ({bus.ovf, bus.c, bus.s} !== exp) begin errors++; $display("FAIL bp_hold[%0d]: got %h want %h", i, {bus.ovf, bus.c, bus.s}, exp); end
      checks++; if ({bus.out_valid, bus.in_ready} !== 2'b10) begin errors++; $display("FAIL bp_hold_hs[%0d]: out_valid/in_ready got %b want 10", i, {bus.out_valid, bus.in_ready}); end
    end
    exp           = model(16'h00F0, 16'h0F0F, 1'b0);
    bus.a         = 16'h00F0;
    bus.b         = 16'h0F0F;
    bus.op        = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin errors++; $display("FAIL bp_release_idle: ready/busy/valid got %b want 100", {bus.in_ready, bus.busy, bus.out_valid}); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if ({bus.in_ready, bus.busy} !== 2'b01) begin errors++; $display("FAIL bp_next_accept: ready/busy got %b want 01", {bus.in_ready, bus.busy}); end
    cnt = 0;
    while (bus.out_valid !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    checks++; if ({bus.ovf, bus.c, bus.s} !== exp) begin errors++; $display("FAIL bp_next_result: got %h want %h", {bus.ovf, bus.c, bus.s}, exp); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [17:0] e1, e2;
    e1            = model(16'hA5A5, 16'h5A5B, 1'b0);
    e2            = model(16'h0100, 16'h0200, 1'b1);
    bus.a         = 16'hA5A5;
    bus.b         = 16'h5A5B;
    bus.op        = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.a  = 16'h0100;
    bus.b  = 16'h0200;
    bus.op = 1'b1;
    repeat (4) tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1: got %b want 1", bus.out_valid); end
    checks++; if ({bus.ovf, bus.c, bus.s} !== e1) begin errors++; $display("FAIL b2b_result1: got %h want %h", {bus.ovf, bus.c, bus.s}, e1); end
    tick();
    checks++; if ({bus.in_ready, bus.out_valid} !== 2'b10) begin errors++; $display("FAIL b2b_idle: ready/valid got %b want 10", {bus.in_ready, bus.out_valid}); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept2: busy got %b want 1", bus.busy); end
    repeat (4) tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2: got %b want 1", bus.out_valid); end
    checks++; if ({bus.ovf, bus.c, bus.s} !== e2) begin errors++; $display("FAIL b2b_result2: got %h want %h", {bus.ovf, bus.c, bus.s}, e2); end
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] rs;
    logic        rc, rv;
    int          lat;
    bus.a        = 16'hFFFF;
    bus.b        = 16'hFFFF;
    bus.op       = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    checks++; if (bus.s[7:0] !== 8'hFE) begin errors++; $display("FAIL mid_partial: low byte got %h want fe", bus.s[7:0]); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin errors++; $display("FAIL mid_rst_hs: ready/busy/valid got %b want 100", {bus.in_ready, bus.busy, bus.out_valid}); end
    checks++; if ({bus.s, bus.c, bus.ovf} !== 18'd0) begin errors++; $display("FAIL mid_rst_result: got s=%h c=%b ovf=%b want 0", bus.s, bus.c, bus.ovf); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_release: in_ready got %b want 1", bus.in_ready); end
    do_op(16'h0001, 16'h0001, 1'b0, 0, rs, rc, rv, lat);
    checks++; if ({rv, rc, rs} !== {2'b00, 16'h0002}) begin errors++; $display("FAIL mid_fresh: got s=%h c=%b ovf=%b want 0002/0/0", rs, rc, rv); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL mid_fresh_latency: got %0d want 4", lat); end
  endtask

`ifdef ADDSUB_SEQ_ABORT_EN
  task automatic test_abort();
    logic [15:0] rs;
    logic        rc, rv;
    int          lat;
    int          seen;
    bus.a        = 16'h1111;
    bus.b        = 16'h2222;
    bus.op       = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++; if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin errors++; $display("FAIL abort_idle: ready/valid/busy got %b want 100", {bus.in_ready, bus.out_valid, bus.busy}); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d valid cycles want 0", seen); end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_idle: in_ready got %b want 1", bus.in_ready); end
    do_op(16'h1111, 16'h2222, 1'b0, 0, rs, rc, rv, lat);
    checks++; if ({rv, rc, rs} !== {2'b00, 16'h3333}) begin errors++; $display("FAIL abort_after: got s=%h c=%b ovf=%b want 3333/0/0", rs, rc, rv); end
  endtask
`endif

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = 1'b0;
`ifdef ADDSUB_SEQ_ABORT_EN
    bus.abort     = 1'b0;
`endif
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
`ifdef ADDSUB_SEQ_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
